memory_access_stage: RTL and testbench

Memory (MEM) stage controller of the 16-bit pipelined CPU. It consumes the EX/MEM bundle and performs loads and stores through a request/acknowledge data-memory port. It stalls the upstream pipeline while an access is outstanding. It then produces the registered write-back bundle (wbs, memData, ALUresult, ni) that feeds the MEM/WB pipeline register.

---
 rtl/memory_access_stage.sv | 174 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM stage controller: runs loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and registers the write-back
// bundle for the MEM/WB pipeline register. A sticky fault is raised if the
// memory never acknowledges within MAX_WAIT cycles.
module memory_access_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // EX/MEM bundle
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] storeData_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              wbs_in,
    input  logic              ni_in,
    output logic              stall_out,
    // Data-memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    // Write-back bundle
    output logic              valid_out,
    output logic              wbs_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic              ni_out,
    output logic              fault_out
);

    localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StFault = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Latched access, held stable for the whole WAIT period
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wbs_q, wbs_d;
    logic              ni_q, ni_d;

    // Registered write-back bundle
    logic              valid_out_q, valid_out_d;
    logic              wbs_out_q, wbs_out_d;
    logic              ni_out_q, ni_out_d;
    logic [DATA_W-1:0] memdata_q, memdata_d;
    logic [DATA_W-1:0] alures_q, alures_d;

    logic mem_op;
    assign mem_op = memRead_in | memWrite_in;

    // Next-state logic for the FSM, latched access and write-back bundle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wbs_d       = wbs_q;
        ni_d        = ni_q;
        // Bubble by default: flags cleared, data fields hold
        valid_out_d = 1'b0;
        wbs_out_d   = 1'b0;
        ni_out_d    = 1'b0;
        memdata_d   = memdata_q;
        alures_d    = alures_q;

        case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (mem_op) begin
                        // Write wins when both flags are set
                        we_d    = memWrite_in;
                        addr_d  = ALUresult_in;
                        wdata_d = storeData_in;
                        wbs_d   = wbs_in;
                        ni_d    = ni_in;
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        valid_out_d = 1'b1;
                        wbs_out_d   = wbs_in;
                        ni_out_d    = ni_in;
                        memdata_d   = '0;
                        alures_d    = ALUresult_in;
                    end
                end
            end
            StWait: begin
                if (mem_ack) begin
                    valid_out_d = 1'b1;
                    wbs_out_d   = wbs_q;
                    ni_out_d    = ni_q;
                    alures_d    = addr_q;
                    memdata_d   = we_q ? '0 : mem_rdata;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFault: begin
                // Terminal until reset
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wbs_q       <= 1'b0;
            ni_q        <= 1'b0;
            valid_out_q <= 1'b0;
            wbs_out_q   <= 1'b0;
            ni_out_q    <= 1'b0;
            memdata_q   <= '0;
            alures_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wbs_q       <= wbs_d;
            ni_q        <= ni_d;
            valid_out_q <= valid_out_d;
            wbs_out_q   <= wbs_out_d;
            ni_out_q    <= ni_out_d;
            memdata_q   <= memdata_d;
            alures_q    <= alures_d;
        end
    end

    // Stall drops in the ack cycle so upstream advances on that edge
    assign stall_out = ((state_q == StIdle) & valid_in & mem_op)
                     | ((state_q == StWait) & ~mem_ack)
                     | (state_q == StFault);

    // mem_req is a pure function of the state register, so it is registered
    assign mem_req       = (state_q == StWait);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign fault_out     = (state_q == StFault);
    assign valid_out     = valid_out_q;
    assign wbs_out       = wbs_out_q;
    assign ni_out        = ni_out_q;
    assign memData_out   = memdata_q;
    assign ALUresult_out = alures_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_memory_access_stage;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_WAIT = 8;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic [DATA_W-1:0] ALUresult_in;
    logic [DATA_W-1:0] storeData_in;
    logic              memRead_in;
    logic              memWrite_in;
    logic              wbs_in;
    logic              ni_in;
    logic              stall_out;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              valid_out;
    logic              wbs_out;
    logic [DATA_W-1:0] memData_out;
    logic [DATA_W-1:0] ALUresult_out;
    logic              ni_out;
    logic              fault_out;

    int errors = 0;
    int checks = 0;

    memory_access_stage #(
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .ALUresult_in  (ALUresult_in),
        .storeData_in  (storeData_in),
        .memRead_in    (memRead_in),
        .memWrite_in   (memWrite_in),
        .wbs_in        (wbs_in),
        .ni_in         (ni_in),
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .valid_out     (valid_out),
        .wbs_out       (wbs_out),
        .memData_out   (memData_out),
        .ALUresult_out (ALUresult_out),
        .ni_out        (ni_out),
        .fault_out     (fault_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_none();
        valid_in     = 1'b0;
        ALUresult_in = '0;
        storeData_in = '0;
        memRead_in   = 1'b0;
        memWrite_in  = 1'b0;
        wbs_in       = 1'b0;
        ni_in        = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic drive_op(input logic [15:0] addr, input logic [15:0] sdata,
                            input logic rd, input logic wr, input logic wbs, input logic ni);
        valid_in     = 1'b1;
        ALUresult_in = addr;
        storeData_in = sdata;
        memRead_in   = rd;
        memWrite_in  = wr;
        wbs_in       = wbs;
        ni_in        = ni;
    endtask

    task automatic test_reset();
        drive_none();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({mem_req, mem_we, valid_out, wbs_out, ni_out, fault_out, stall_out} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {mem_req, mem_we, valid_out, wbs_out, ni_out, fault_out, stall_out});
        end
        checks++;
        if ({mem_addr, mem_wdata, memData_out, ALUresult_out} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {mem_addr, mem_wdata, memData_out, ALUresult_out});
        end
        #5;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_op();
        drive_op(16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b want 0", stall_out);
        end
        tick();
        drive_none();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out, stall_out, mem_req} !== 5'b11100) begin
            errors++;
            $display("FAIL alu_flags: got %b want 11100",
                     {valid_out, wbs_out, ni_out, stall_out, mem_req});
        end
        checks++;
        if (ALUresult_out !== 16'hABCD || memData_out !== 16'h0000) begin
            errors++;
            $display("FAIL alu_data: got %h/%h want abcd/0000", ALUresult_out, memData_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out} !== 3'b000 || ALUresult_out !== 16'hABCD) begin
            errors++;
            $display("FAIL alu_bubble: got %b %h want 000 abcd",
                     {valid_out, wbs_out, ni_out}, ALUresult_out);
        end
        tick();
    endtask

    task automatic test_load();
        drive_op(16'h0040, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_accept: stall/req got %b%b want 10", stall_out, mem_req);
        end
        tick();
        // Upstream keeps the stalled load bundle presented during WAIT
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h1234;
            end
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
                errors++;
                $display("FAIL load_req_c%0d: req/we/addr got %b%b %h want 10 0040",
                         c, mem_req, mem_we, mem_addr);
            end
            checks++;
            if (stall_out !== (c != 3)) begin
                errors++;
                $display("FAIL load_stall_c%0d: got %b want %b", c, stall_out, (c != 3));
            end
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL load_early_valid_c%0d: got %b want 0", c, valid_out);
            end
            tick();
        end
        drive_none();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out, mem_req, stall_out} !== 5'b11000) begin
            errors++;
            $display("FAIL load_done_flags: got %b want 11000",
                     {valid_out, wbs_out, ni_out, mem_req, stall_out});
        end
        checks++;
        if (memData_out !== 16'h1234 || ALUresult_out !== 16'h0040) begin
            errors++;
            $display("FAIL load_done_data: got %h/%h want 1234/0040", memData_out, ALUresult_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL load_single_pulse: got %b want 0", valid_out);
        end
        tick();
    endtask

    task automatic test_store();
        // Both read and write set: treated as a store
        drive_op(16'h0010, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h5678
            || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL store_req: req/we/wdata/addr got %b%b %h %h want 11 5678 0010",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        tick();
        drive_none();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out} !== 3'b101 || memData_out !== 16'h0000
            || ALUresult_out !== 16'h0010) begin
            errors++;
            $display("FAIL store_done: got %b %h %h want 101 0000 0010",
                     {valid_out, wbs_out, ni_out}, memData_out, ALUresult_out);
        end
        tick();
    endtask

    task automatic test_ack_ignored_idle();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || mem_req !== 1'b0 || memData_out !== 16'h0000) begin
            errors++;
            $display("FAIL idle_ack: valid/req/data got %b%b %h want 00 0000",
                     valid_out, mem_req, memData_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_op(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h4321;
        tick();
        // Upstream advanced on the ack edge: ALU op now presented
        mem_ack = 1'b0;
        drive_op(16'h9876, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b1 || memData_out !== 16'h4321 || ALUresult_out !== 16'h0020
            || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid/data/addr/stall got %b %h %h %b want 1 4321 0020 0",
                     valid_out, memData_out, ALUresult_out, stall_out);
        end
        tick();
        drive_none();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out} !== 3'b101 || ALUresult_out !== 16'h9876
            || memData_out !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_second: got %b %h %h want 101 9876 0000",
                     {valid_out, wbs_out, ni_out}, ALUresult_out, memData_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_dup: valid/req got %b%b want 00", valid_out, mem_req);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive_op(16'h0050, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive_none();
        for (int c = 1; c <= MAX_WAIT; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || stall_out !== 1'b1 || fault_out !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait_c%0d: req/stall/fault got %b%b%b want 110",
                         c, mem_req, stall_out, fault_out);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({fault_out, mem_req, stall_out, valid_out} !== 4'b1010) begin
            errors++;
            $display("FAIL timeout_fault: fault/req/stall/valid got %b want 1010",
                     {fault_out, mem_req, stall_out, valid_out});
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        drive_op(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if ({fault_out, mem_req, stall_out, valid_out} !== 4'b1010
            || memData_out === 16'h7777) begin
            errors++;
            $display("FAIL timeout_sticky: flags %b data %h want 1010, data not 7777",
                     {fault_out, mem_req, stall_out, valid_out}, memData_out);
        end
        drive_none();
        rst_n = 1'b0;
        #2;
        checks++;
        if (fault_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL fault_reset: fault/stall got %b%b want 00", fault_out, stall_out);
        end
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive_op(16'h0060, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive_none();
        tick();
        // Now in the 2nd WAIT cycle
        #2;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre: req got %b want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, valid_out, wbs_out, ni_out, fault_out, stall_out} !== 7'b0
            || {mem_addr, mem_wdata, memData_out, ALUresult_out} !== 64'h0) begin
            errors++;
            $display("FAIL rstwait_outputs: flags %b data %h want 0",
                     {mem_req, mem_we, valid_out, wbs_out, ni_out, fault_out, stall_out},
                     {mem_addr, mem_wdata, memData_out, ALUresult_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_abandon: valid/req got %b%b want 00", valid_out, mem_req);
        end
        tick();
        drive_op(16'h1357, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_none();
        @(negedge clk);
        checks++;
        if ({valid_out, wbs_out, ni_out} !== 3'b110 || ALUresult_out !== 16'h1357
            || memData_out !== 16'h0000) begin
            errors++;
            $display("FAIL rstwait_alu: got %b %h %h want 110 1357 0000",
                     {valid_out, wbs_out, ni_out}, ALUresult_out, memData_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_ack_ignored_idle();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
